// File: rtl/gprf_wb_sched.sv
// GPR write-port scheduler: load returns beat ALU writebacks; in-order load rd-tag FIFO drives RAW/WAW hazard flags.
// Latency: zero; the write port is combinational from the winning handshake and lands at the closing posedge.
// Backpressure: an ALU write stalls during a load return or a WAW hit; issue stalls only when full with no pop.
module gprf_wb_sched #(
  parameter int XLEN           = 32,
  parameter int GPR_AW         = 5,
  parameter int LD_OUTSTANDING = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  alu_wb_vld,
  output logic                                  alu_wb_rdy,
  input  logic [GPR_AW-1:0]                     alu_wb_rd,
  input  logic [XLEN-1:0]                       alu_wb_data,
  input  logic                                  ld_iss_vld,
  output logic                                  ld_iss_rdy,
  input  logic [GPR_AW-1:0]                     ld_iss_rd,
  input  logic                                  ld_wb_vld,
  output logic                                  ld_wb_rdy,
  input  logic [XLEN-1:0]                       ld_wb_data,
  input  logic [GPR_AW-1:0]                     chk_raddr1,
  input  logic [GPR_AW-1:0]                     chk_raddr2,
  input  logic [GPR_AW-1:0]                     chk_waddr,
  output logic                                  chk_busy,
  output logic [GPR_AW-1:0]                     gpr_waddr,
  output logic [XLEN-1:0]                       gpr_wdata,
  output logic                                  gpr_wen,
  output logic [$clog2(LD_OUTSTANDING+1)-1:0]   ld_pend_cnt
);

  localparam int PW = (LD_OUTSTANDING > 1) ? $clog2(LD_OUTSTANDING) : 1;
  localparam int CW = $clog2(LD_OUTSTANDING + 1);
  localparam logic [CW-1:0] DEPTH = CW'(LD_OUTSTANDING);
  localparam logic [PW-1:0] LAST  = PW'(LD_OUTSTANDING - 1);

  logic [GPR_AW-1:0]         tag_q [LD_OUTSTANDING];
  logic [GPR_AW-1:0]         tag_d [LD_OUTSTANDING];
  logic [LD_OUTSTANDING-1:0] ent_vld_q, ent_vld_d;
  logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]             cnt_q, cnt_d;

  logic ld_push, ld_pop, alu_hs, waw_hit;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // Handshakes: a load return always wins the write port; a full FIFO still accepts a push when it pops.
  assign ld_wb_rdy   = (cnt_q != '0);
  assign ld_pop      = ld_wb_vld && ld_wb_rdy;
  assign ld_iss_rdy  = (cnt_q < DEPTH) || ld_pop;
  assign ld_push     = ld_iss_vld && ld_iss_rdy;
  assign alu_wb_rdy  = !ld_pop && !waw_hit;
  assign alu_hs      = alu_wb_vld && alu_wb_rdy;
  assign ld_pend_cnt = cnt_q;

  // Hazard match against pending non-x0 load destinations (current contents only)
  always_comb begin
    waw_hit  = 1'b0;
    chk_busy = 1'b0;
    for (int i = 0; i < LD_OUTSTANDING; i++) begin
      if (ent_vld_q[i] && (tag_q[i] != '0)) begin
        if (tag_q[i] == alu_wb_rd) waw_hit = 1'b1;
        if ((tag_q[i] == chk_raddr1) || (tag_q[i] == chk_raddr2) || (tag_q[i] == chk_waddr))
          chk_busy = 1'b1;
      end
    end
  end

  // Write port mux: load return first, then ALU; x0 writes complete but are not enabled
  always_comb begin
    gpr_wen   = 1'b0;
    gpr_waddr = '0;
    gpr_wdata = '0;
    if (ld_pop) begin
      gpr_waddr = tag_q[rd_ptr_q];
      gpr_wdata = ld_wb_data;
      gpr_wen   = (tag_q[rd_ptr_q] != '0);
    end else if (alu_hs) begin
      gpr_waddr = alu_wb_rd;
      gpr_wdata = alu_wb_data;
      gpr_wen   = (alu_wb_rd != '0);
    end
  end

  // FIFO next state: pop clears the head first so a full-FIFO push into the same slot stays valid
  always_comb begin
    tag_d     = tag_q;
    ent_vld_d = ent_vld_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (ld_pop) begin
      ent_vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d            = ptr_inc(rd_ptr_q);
    end
    if (ld_push) begin
      ent_vld_d[wr_ptr_q] = 1'b1;
      tag_d[wr_ptr_q]     = ld_iss_rd;
      wr_ptr_d            = ptr_inc(wr_ptr_q);
    end
    cnt_d = cnt_q + CW'(ld_push) - CW'(ld_pop);
  end

  // State registers; reset drops every outstanding load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LD_OUTSTANDING; i++) tag_q[i] <= '0;
      ent_vld_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      tag_q     <= tag_d;
      ent_vld_q <= ent_vld_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_gprf_wb_sched.sv
// Bench for gprf_wb_sched: directed vectors; GPR writes are checked by a scoreboard monitor,
// handshake and status outputs by direct checks in the stimulus thread.
// Inputs change 1ns after posedge; everything is sampled mid-cycle or at negedge.
module tb_gprf_wb_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_wb_vld, alu_wb_rdy;
  logic [4:0]  alu_wb_rd;
  logic [31:0] alu_wb_data;
  logic        ld_iss_vld, ld_iss_rdy;
  logic [4:0]  ld_iss_rd;
  logic        ld_wb_vld, ld_wb_rdy;
  logic [31:0] ld_wb_data;
  logic [4:0]  chk_raddr1, chk_raddr2, chk_waddr;
  logic        chk_busy;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic        gpr_wen;
  logic [1:0]  ld_pend_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [36:0] exp_q[$];   // {waddr, wdata}

  always #5 clk = ~clk;

  gprf_wb_sched #(.XLEN(32), .GPR_AW(5), .LD_OUTSTANDING(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_wb_vld(alu_wb_vld), .alu_wb_rdy(alu_wb_rdy), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
    .ld_iss_vld(ld_iss_vld), .ld_iss_rdy(ld_iss_rdy), .ld_iss_rd(ld_iss_rd),
    .ld_wb_vld(ld_wb_vld), .ld_wb_rdy(ld_wb_rdy), .ld_wb_data(ld_wb_data),
    .chk_raddr1(chk_raddr1), .chk_raddr2(chk_raddr2), .chk_waddr(chk_waddr), .chk_busy(chk_busy),
    .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata), .gpr_wen(gpr_wen), .ld_pend_cnt(ld_pend_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // Scoreboard monitor: every enabled write must match the oldest expected write
  initial begin
    logic [36:0] e;
    forever begin
      @(negedge clk);
      if (gpr_wen === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write: got addr %0d data %0h, expected no write", gpr_waddr, gpr_wdata);
        end else begin
          e = exp_q.pop_front();
          if ({gpr_waddr, gpr_wdata} !== e) begin
            n_err++;
            $display("FAIL gpr_write: got addr %0d data %0h, expected addr %0d data %0h",
                     gpr_waddr, gpr_wdata, e[36:32], e[31:0]);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    alu_wb_vld = 0; alu_wb_rd = 0; alu_wb_data = 0;
    ld_iss_vld = 0; ld_iss_rd = 0;
    ld_wb_vld = 0; ld_wb_data = 0;
    chk_raddr1 = 0; chk_raddr2 = 0; chk_waddr = 0;
    #2;
    chk("rst_cnt", ld_pend_cnt, 0);
    chk("rst_ld_wb_rdy", ld_wb_rdy, 0);
    chk("rst_ld_iss_rdy", ld_iss_rdy, 1);
    chk("rst_busy", chk_busy, 0);
    chk("rst_wen", gpr_wen, 0);
    chk("rst_alu_rdy", alu_wb_rdy, 1);
    step(); step();
    rst_n = 1'b1;
    step();

    // ALU only, then ALU to x0
    alu_wb_vld = 1; alu_wb_rd = 5; alu_wb_data = 32'h1234;
    expect_wr(5, 32'h1234);
    #1 chk("alu_rdy", alu_wb_rdy, 1);
    chk("alu_wen", gpr_wen, 1);
    step();
    alu_wb_rd = 0; alu_wb_data = 32'h5678;
    #1 chk("alu_x0_rdy", alu_wb_rdy, 1);
    chk("alu_x0_wen", gpr_wen, 0);
    step();
    alu_wb_vld = 0;

    // Single load: reserve, hazard visible next cycle, return, hazard clears
    ld_iss_vld = 1; ld_iss_rd = 3;
    #1 chk("iss_rdy", ld_iss_rdy, 1);
    chk("busy_not_yet", chk_busy, 0);
    step();
    ld_iss_vld = 0; chk_raddr1 = 3;
    #1 chk("ld_busy", chk_busy, 1);
    chk("ld_cnt1", ld_pend_cnt, 1);
    chk("ld_wb_rdy1", ld_wb_rdy, 1);
    step();
    ld_wb_vld = 1; ld_wb_data = 32'hDEADBEEF;
    expect_wr(3, 32'hDEADBEEF);
    #1 chk("busy_on_pop", chk_busy, 1);
    step();
    ld_wb_vld = 0;
    #1 chk("busy_cleared", chk_busy, 0);
    chk("cnt_back0", ld_pend_cnt, 0);
    chk_raddr1 = 0;

    // WAW: ALU rd=7 blocked while load to 7 pending
    ld_iss_vld = 1; ld_iss_rd = 7;
    step();
    ld_iss_vld = 0;
    alu_wb_vld = 1; alu_wb_rd = 7; alu_wb_data = 32'h77;
    #1 chk("waw_block", alu_wb_rdy, 0);
    chk("waw_no_wen", gpr_wen, 0);
    step();
    #1 chk("waw_block2", alu_wb_rdy, 0);
    ld_wb_vld = 1; ld_wb_data = 32'hAAAA;
    expect_wr(7, 32'hAAAA);
    #1 chk("ld_prio", alu_wb_rdy, 0);
    step();
    ld_wb_vld = 0;
    expect_wr(7, 32'h77);
    #1 chk("waw_release", alu_wb_rdy, 1);
    step();
    alu_wb_vld = 0;

    // Priority: load return and unrelated ALU write in the same cycle
    ld_iss_vld = 1; ld_iss_rd = 7;
    step();
    ld_iss_vld = 0;
    alu_wb_vld = 1; alu_wb_rd = 9; alu_wb_data = 32'h99;
    ld_wb_vld = 1; ld_wb_data = 32'hBBBB;
    expect_wr(7, 32'hBBBB);
    #1 chk("prio_alu_wait", alu_wb_rdy, 0);
    step();
    ld_wb_vld = 0;
    expect_wr(9, 32'h99);
    #1 chk("prio_alu_go", alu_wb_rdy, 1);
    step();
    alu_wb_vld = 0;

    // Full and wrap
    ld_iss_vld = 1; ld_iss_rd = 1;
    step();
    ld_iss_rd = 2;
    step();
    ld_iss_vld = 0;
    #1 chk("full_cnt", ld_pend_cnt, 2);
    chk("full_iss_rdy", ld_iss_rdy, 0);
    ld_iss_vld = 1; ld_iss_rd = 4;
    ld_wb_vld = 1; ld_wb_data = 32'h1111;
    expect_wr(1, 32'h1111);
    #1 chk("full_pushpop_rdy", ld_iss_rdy, 1);
    step();
    ld_iss_vld = 0;
    #1 chk("full_cnt_kept", ld_pend_cnt, 2);
    ld_wb_data = 32'h2222;
    expect_wr(2, 32'h2222);
    step();
    ld_wb_data = 32'h4444;
    expect_wr(4, 32'h4444);
    step();
    ld_wb_vld = 0;
    #1 chk("drain_cnt", ld_pend_cnt, 0);

    // Load return with nothing pending, plus an x0 reservation in the same cycle
    ld_wb_vld = 1; ld_wb_data = 32'h5555;
    ld_iss_vld = 1; ld_iss_rd = 0;
    #1 chk("empty_wb_rdy", ld_wb_rdy, 0);
    chk("empty_wen", gpr_wen, 0);
    step();
    ld_wb_vld = 0; ld_iss_vld = 0;
    #1 chk("x0_cnt", ld_pend_cnt, 1);
    chk("x0_busy", chk_busy, 0);
    ld_wb_vld = 1;
    #1 chk("x0_pop_rdy", ld_wb_rdy, 1);
    chk("x0_pop_wen", gpr_wen, 0);
    step();
    ld_wb_vld = 0;
    #1 chk("x0_cnt0", ld_pend_cnt, 0);

    // Asynchronous reset mid-operation
    ld_iss_vld = 1; ld_iss_rd = 10;
    step();
    ld_iss_rd = 11;
    step();
    ld_iss_vld = 0; chk_raddr2 = 10;
    #1 chk("pre_rst_cnt", ld_pend_cnt, 2);
    chk("pre_rst_busy", chk_busy, 1);
    #1 rst_n = 1'b0;
    #1 chk("arst_cnt", ld_pend_cnt, 0);
    chk("arst_wb_rdy", ld_wb_rdy, 0);
    chk("arst_iss_rdy", ld_iss_rdy, 1);
    chk("arst_busy", chk_busy, 0);
    chk("arst_alu_rdy", alu_wb_rdy, 1);
    step();
    rst_n = 1'b1;
    step();
    #1 chk("post_rst_busy", chk_busy, 0);
    chk_raddr2 = 0;
    step(); step();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gprf_wb_sched.md
Name: gprf_wb_sched

Overview:
- Arbitrates the single GPR file write port between two sources:
  - single-cycle ALU/handler writebacks from the EXU;
  - load-data returns from the load/store path.
- Tracks outstanding loads in an in-order rd-tag FIFO (LD_OUTSTANDING entries) and flags RAW/WAW hazards against pending load destinations, so the EXU can stall issue.
- Sits between the EXU instruction handlers / ldst response path and the GPR file write interface.

Parameters:
- XLEN, 32, data width (matches RV_XLEN)
- GPR_AW, 5, GPR address width (matches RV_GPR_AW)
- LD_OUTSTANDING, 2, maximum loads issued but not yet written back; must be >= 1

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- alu_wb_vld  in  1  ALU/handler writeback request
- alu_wb_rdy  out  1  ALU writeback accepted this cycle
- alu_wb_rd  in  GPR_AW  ALU destination register
- alu_wb_data  in  XLEN  ALU result
- ld_iss_vld  in  1  load being issued; reserve its rd
- ld_iss_rdy  out  1  tag FIFO can accept a reservation
- ld_iss_rd  in  GPR_AW  load destination register
- ld_wb_vld  in  1  load data returning (in issue order)
- ld_wb_rdy  out  1  load return accepted
- ld_wb_data  in  XLEN  load data
- chk_raddr1  in  GPR_AW  issue-stage source 1 to check
- chk_raddr2  in  GPR_AW  issue-stage source 2 to check
- chk_waddr  in  GPR_AW  issue-stage destination to check
- chk_busy  out  1  any checked register has a pending load
- gpr_waddr  out  GPR_AW  GPR write address
- gpr_wdata  out  XLEN  GPR write data
- gpr_wen  out  1  GPR write enable (GPR file samples on posedge clk)
- ld_pend_cnt  out  $clog2(LD_OUTSTANDING+1)  number of outstanding loads

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-low on rst_n.
- State:
  - tag FIFO of LD_OUTSTANDING entries, each holding an rd;
  - wr_ptr and rd_ptr, each wrapping modulo LD_OUTSTANDING;
  - occupancy count; ld_pend_cnt is the count.
- Handshakes: each transfer completes on a cycle where vld && rdy. vld/payload must hold until rdy. No combinational path from any rdy to any vld.
- ld_wb_rdy = (cnt != 0). ld_wb_vld while cnt == 0 is a protocol error: not accepted, no write.
- ld_iss_rdy = (cnt < LD_OUTSTANDING) || (ld_wb_vld && ld_wb_rdy). When full, a push and pop in the same cycle are legal.
- waw_hit: alu_wb_rd != 0 and alu_wb_rd matches any valid FIFO entry.
- alu_wb_rdy = !(ld_wb_vld && ld_wb_rdy) && !waw_hit. Load return has strict priority; an ALU write never overtakes an older load to the same rd.
- Write port (combinational, zero latency; the write lands at the posedge ending the handshake cycle):
  - ld_wb handshake: gpr_waddr = FIFO head rd, gpr_wdata = ld_wb_data.
  - else alu_wb handshake: gpr_waddr = alu_wb_rd, gpr_wdata = alu_wb_data.
  - else gpr_wen = 0, gpr_waddr = 0, gpr_wdata = 0.
  - gpr_wen = handshake && (selected waddr != 0). Writes to x0 complete their handshake but are suppressed.
- Loads to x0 are still pushed (a tag is needed for in-order return) but never cause a hazard.
- chk_busy: OR, over valid FIFO entries with rd != 0, of a match against chk_raddr1, chk_raddr2 or chk_waddr.
  - Reflects current-cycle FIFO contents only.
  - A reservation pushed this cycle is visible from the next cycle.
  - The entry popped this cycle still reports busy this cycle.
- Counter update: cnt_next = cnt + push - pop.
  - Simultaneous push/pop leaves cnt unchanged and advances both pointers.
  - Push into an empty FIFO with ld_wb_vld high in the same cycle: no pop (ld_wb_rdy = 0).
- Reset values (async, also mid-operation): pointers = 0, cnt = 0, all FIFO entries invalid.
  - This gives ld_pend_cnt = 0, ld_wb_rdy = 0, ld_iss_rdy = 1, chk_busy = 0, gpr_wen = 0.
  - alu_wb_rdy = 1 while in reset.
  - Outstanding loads are dropped; the ldst path must also be reset.

Test Plan:
- ALU only: alu_wb_vld = 1, rd = 5, data = 0x1234 → same cycle alu_wb_rdy = 1, gpr_wen = 1, waddr = 5, wdata = 0x1234. Repeat with rd = 0 → rdy = 1, gpr_wen = 0.
- Load sequence: issue rd = 3; next cycle chk_raddr1 = 3 → chk_busy = 1, ld_pend_cnt = 1. ld_wb data 0xDEADBEEF → gpr_wen = 1, waddr = 3; next cycle chk_busy = 0, cnt = 0.
- Priority/WAW: one load pending rd = 7; ALU rd = 7 → alu_wb_rdy = 0 until load returns. Same cycle ld_wb and ALU rd = 9 → load writes, ALU written next cycle.
- Full and wrap: issue rd = 1, 2 → cnt = 2, ld_iss_rdy = 0. Then issue rd = 4 with ld_wb returning rd = 1 → accepted, cnt stays 2. Returns write rd 2 then 4 in order.
- Error/empty: ld_wb_vld = 1 with cnt = 0 → ld_wb_rdy = 0, gpr_wen = 0. Issue to x0, then chk_raddr1 = 0 → chk_busy = 0.
- Reset mid-op: two loads pending, assert rst_n = 0 asynchronously → cnt = 0, ld_wb_rdy = 0, ld_iss_rdy = 1, chk_busy = 0 immediately, without waiting for a clock edge.
